io_channel_bridge: RTL and testbench

// - Sits directly downstream/upstream of the processor I/O port: consumes dev_out/enter_out, produces dev_in/enter_in/done_out.
// - Connects 4 x 32-bit channels to board devices: input channels (switches plus push-button) and output channels (display/LED registers).
// - Per channel: button synchroniser, debounce, one-entry input buffer, request/ack FSM with modelled device latency.

---
 rtl/io_channel_bridge_if.sv | 37 +++
 rtl/io_channel_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_io_channel_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_channel_bridge_if.sv
// -----------------------------------------------------------------------------
// io_channel_bridge_if
// Groups the processor-side and board-side signals of the I/O channel bridge.
//   dev_out       [127:0]  processor data, channel i = [32*i+31:32*i]
//   enter_out     [3:0]    processor request level per channel
//   dev_in        [127:0]  data delivered to the processor
//   enter_in      [3:0]    1-cycle pulse, dev_in slice valid
//   done_out      [3:0]    output-channel acknowledge level
//   ext_in        [127:0]  raw switch values
//   ext_btn       [3:0]    raw asynchronous push-buttons
//   ext_out       [127:0]  display registers
//   ext_out_valid [3:0]    1-cycle strobe when an ext_out slice updates
//   overrun       [3:0]    sticky: a press was lost because the buffer was full
// master: the processor/board side.  slave: the bridge.
// -----------------------------------------------------------------------------
interface io_channel_bridge_if;
    logic [127:0] dev_out;
    logic [3:0]   enter_out;
    logic [127:0] dev_in;
    logic [3:0]   enter_in;
    logic [3:0]   done_out;
    logic [127:0] ext_in;
    logic [3:0]   ext_btn;
    logic [127:0] ext_out;
    logic [3:0]   ext_out_valid;
    logic [3:0]   overrun;

    modport master (
        output dev_out, enter_out, ext_in, ext_btn,
        input  dev_in, enter_in, done_out, ext_out, ext_out_valid, overrun
    );

    modport slave (
        input  dev_out, enter_out, ext_in, ext_btn,
        output dev_in, enter_in, done_out, ext_out, ext_out_valid, overrun
    );
endinterface

// File: rtl/io_channel_bridge.sv
// -----------------------------------------------------------------------------
// io_channel_bridge
// Connects the processor I/O port to four 32-bit board channels. Each channel
// is either an input channel (switches + push-button, debounced, one-entry
// buffer, request/deliver FSM) or an output channel (display register with a
// modelled acknowledge latency), selected by OUT_MASK.
// Ports:
//   clk    rising-edge clock shared with the processor
//   reset  synchronous, active-high
//   bus    io_channel_bridge_if.slave (processor and board signals)
// Parameters:
//   OUT_MASK   bit i=1: channel i is an output channel
//   DEBOUNCE   cycles the synchronised button must stay high (min 1)
//   ACK_DELAY  cycles from output capture to the start of the ack; 0 = next cycle
// -----------------------------------------------------------------------------
module io_channel_bridge #(
    parameter logic [3:0]  OUT_MASK  = 4'b1100,
    parameter logic [15:0] DEBOUNCE  = 16'd4,
    parameter logic [7:0]  ACK_DELAY = 8'd3
) (
    input  logic              clk,
    input  logic              reset,
    io_channel_bridge_if.slave bus
);

    // Input-channel FSM states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DELIVER  = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

    // Output-channel FSM states
    localparam logic [1:0] ST_O_IDLE   = 2'd0;
    localparam logic [1:0] ST_O_BUSY   = 2'd1;
    localparam logic [1:0] ST_O_ACK    = 2'd2;

    logic [3:0][31:0] w_dev_in;
    logic [3:0][31:0] w_ext_out;
    logic [3:0]       w_enter_in;
    logic [3:0]       w_done_out;
    logic [3:0]       w_ext_out_valid;
    logic [3:0]       w_overrun;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_ch
            logic [31:0] w_dev_out_sl;
            logic [31:0] w_ext_in_sl;
            logic        w_enter_out;
            logic        w_press;

            // Button path registers
            logic        r_sync1;
            logic        r_sync2;
            logic [15:0] r_db_cnt;

            // Input buffer and request FSM
            logic        r_pending;
            logic [31:0] r_hold;
            logic        r_overrun;
            logic [1:0]  r_in_state;
            logic [31:0] r_dev_in;
            logic        r_enter_in;

            // Output capture and ack FSM
            logic        r_enter_prev;
            logic [1:0]  r_out_state;
            logic [7:0]  r_ack_cnt;
            logic [31:0] r_ext_out;
            logic        r_ext_out_valid;
            logic        r_done;

            assign w_dev_out_sl = bus.dev_out[32*gi +: 32];
            assign w_ext_in_sl  = bus.ext_in[32*gi +: 32];
            assign w_enter_out  = bus.enter_out[gi];

            // One event per press: fires on the cycle the count would reach
            // DEBOUNCE; the counter then saturates until the button is released.
            assign w_press = r_sync2 && (r_db_cnt == (DEBOUNCE - 16'd1));

            // Button synchroniser and debounce counter
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_db_cnt <= 16'd0;
                end else begin
                    r_sync1 <= bus.ext_btn[gi];
                    r_sync2 <= r_sync1;
                    if (!r_sync2) begin
                        r_db_cnt <= 16'd0;
                    end else if (r_db_cnt != DEBOUNCE) begin
                        r_db_cnt <= r_db_cnt + 16'd1;
                    end else begin
                        r_db_cnt <= r_db_cnt;
                    end
                end
            end

            // Input buffer, overrun flag and request/deliver FSM
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pending  <= 1'b0;
                    r_hold     <= 32'd0;
                    r_overrun  <= 1'b0;
                    r_in_state <= ST_IDLE;
                    r_dev_in   <= 32'd0;
                    r_enter_in <= 1'b0;
                end else begin
                    r_enter_in <= 1'b0;

                    // Buffer: the oldest press is kept; later ones are dropped.
                    // The entry stays occupied through DELIVER, so a press
                    // landing in that cycle counts as lost.
                    if (w_press && r_pending) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end

                    if (r_in_state == ST_DELIVER) begin
                        r_pending <= 1'b0;
                    end else if (w_press && !r_pending) begin
                        r_hold    <= w_ext_in_sl;
                        r_pending <= 1'b1;
                    end else begin
                        r_pending <= r_pending;
                    end

                    // dev_in and the pulse are loaded on entry so both are
                    // visible during the single DELIVER cycle.
                    case (r_in_state)
                        ST_IDLE: begin
                            if (w_enter_out && r_pending) begin
                                r_dev_in   <= r_hold;
                                r_enter_in <= 1'b1;
                                r_in_state <= ST_DELIVER;
                            end else begin
                                r_in_state <= ST_IDLE;
                            end
                        end
                        ST_DELIVER: begin
                            r_in_state <= ST_WAIT_REL;
                        end
                        ST_WAIT_REL: begin
                            if (!w_enter_out) begin
                                r_in_state <= ST_IDLE;
                            end else begin
                                r_in_state <= ST_WAIT_REL;
                            end
                        end
                        default: begin
                            r_in_state <= ST_IDLE;
                        end
                    endcase
                end
            end

            // Output capture on request rising edge and delayed acknowledge
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_enter_prev    <= 1'b0;
                    r_out_state     <= ST_O_IDLE;
                    r_ack_cnt       <= 8'd0;
                    r_ext_out       <= 32'd0;
                    r_ext_out_valid <= 1'b0;
                    r_done          <= 1'b0;
                end else begin
                    r_enter_prev    <= w_enter_out;
                    r_ext_out_valid <= 1'b0;
                    case (r_out_state)
                        ST_O_IDLE: begin
                            if (w_enter_out && !r_enter_prev) begin
                                r_ext_out       <= w_dev_out_sl;
                                r_ext_out_valid <= 1'b1;
                                r_ack_cnt       <= ACK_DELAY;
                                r_out_state     <= ST_O_BUSY;
                            end else begin
                                r_out_state <= ST_O_IDLE;
                            end
                        end
                        ST_O_BUSY: begin
                            // Rising edges here are ignored; a dropped request
                            // still receives its ack.
                            if (r_ack_cnt != 8'd0) begin
                                r_ack_cnt <= r_ack_cnt - 8'd1;
                            end else begin
                                r_done      <= 1'b1;
                                r_out_state <= ST_O_ACK;
                            end
                        end
                        ST_O_ACK: begin
                            if (!w_enter_out) begin
                                r_done      <= 1'b0;
                                r_out_state <= ST_O_IDLE;
                            end else begin
                                r_out_state <= ST_O_ACK;
                            end
                        end
                        default: begin
                            r_done      <= 1'b0;
                            r_out_state <= ST_O_IDLE;
                        end
                    endcase
                end
            end

            // Each channel exposes only the outputs that belong to its direction.
            assign w_dev_in[gi]        = OUT_MASK[gi] ? 32'd0 : r_dev_in;
            assign w_enter_in[gi]      = OUT_MASK[gi] ? 1'b0  : r_enter_in;
            assign w_overrun[gi]       = OUT_MASK[gi] ? 1'b0  : r_overrun;
            assign w_ext_out[gi]       = OUT_MASK[gi] ? r_ext_out       : 32'd0;
            assign w_ext_out_valid[gi] = OUT_MASK[gi] ? r_ext_out_valid : 1'b0;
            assign w_done_out[gi]      = OUT_MASK[gi] ? r_done          : 1'b0;
        end
    endgenerate

    assign bus.dev_in        = w_dev_in;
    assign bus.enter_in      = w_enter_in;
    assign bus.overrun       = w_overrun;
    assign bus.ext_out       = w_ext_out;
    assign bus.ext_out_valid = w_ext_out_valid;
    assign bus.done_out      = w_done_out;

endmodule

// File: tb/tb_io_channel_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_channel_bridge
// Directed stimulus for io_channel_bridge with a scoreboard: expected
// deliveries (enter_in) and display updates (ext_out_valid) are queued when
// stimulus is issued, and a negedge monitor pops and compares them whenever
// the bridge presents one. Level signals (done_out, overrun, reset state) are
// checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_io_channel_bridge;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t in_q[$];
    exp_t out_q[$];
    exp_t mon_e;

    io_channel_bridge_if bus();

    io_channel_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_in(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = ch;
        e.data = d;
        in_q.push_back(e);
    endtask

    task automatic push_out(input int ch, input logic [31:0] d);
        exp_t e;
        e.ch = ch;
        e.data = d;
        out_q.push_back(e);
    endtask

    // Scoreboard monitor: every delivery pulse and display strobe must match
    // the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.enter_in[i]) begin
                    n_checks++;
                    if (in_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_delivery ch%0d: got %h required no pulse", i, bus.dev_in[32*i +: 32]);
                    end else begin
                        mon_e = in_q.pop_front();
                        if (mon_e.ch != i || mon_e.data !== bus.dev_in[32*i +: 32]) begin
                            n_errors++;
                            $display("FAIL delivery: got ch%0d %h required ch%0d %h", i, bus.dev_in[32*i +: 32], mon_e.ch, mon_e.data);
                        end
                    end
                end
                if (bus.ext_out_valid[i]) begin
                    n_checks++;
                    if (out_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_strobe ch%0d: got %h required no strobe", i, bus.ext_out[32*i +: 32]);
                    end else begin
                        mon_e = out_q.pop_front();
                        if (mon_e.ch != i || mon_e.data !== bus.ext_out[32*i +: 32]) begin
                            n_errors++;
                            $display("FAIL display: got ch%0d %h required ch%0d %h", i, bus.ext_out[32*i +: 32], mon_e.ch, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset with every input active: all outputs must stay 0.
        reset             = 1'b1;
        bus.dev_out       = {128{1'b1}};
        bus.enter_out     = 4'hF;
        bus.ext_in        = {128{1'b1}};
        bus.ext_btn       = 4'hF;
        step(1);
        for (int k = 0; k < 3; k++) begin
            check("rst_dev_in",        bus.dev_in, 128'd0);
            check("rst_ext_out",       bus.ext_out, 128'd0);
            check("rst_flags",         {112'd0, bus.enter_in, bus.done_out, bus.ext_out_valid, bus.overrun}, 128'd0);
            step(1);
        end
        bus.dev_out   = 128'd0;
        bus.enter_out = 4'h0;
        bus.ext_in    = 128'd0;
        bus.ext_btn   = 4'h0;
        step(2);
        reset = 1'b0;
        step(2);

        // ch0: press with 0x1234, then request -> single delivery.
        bus.ext_in[31:0] = 32'h0000_1234;
        push_in(0, 32'h0000_1234);
        bus.ext_btn[0] = 1'b1;
        step(10);
        bus.ext_btn[0] = 1'b0;
        bus.enter_out[0] = 1'b1;
        step(1);
        check("ch0_pulse_on", {127'd0, bus.enter_in[0]}, 128'd1);
        check("ch0_data", {96'd0, bus.dev_in[31:0]}, {96'd0, 32'h0000_1234});
        step(1);
        check("ch0_pulse_off", {127'd0, bus.enter_in[0]}, 128'd0);
        step(5);
        bus.enter_out[0] = 1'b0;
        step(2);
        bus.enter_out[0] = 1'b1;
        step(5);
        check("ch0_dev_in_held", {96'd0, bus.dev_in[31:0]}, {96'd0, 32'h0000_1234});
        bus.enter_out[0] = 1'b0;
        step(2);

        // ch0: 2- and 3-cycle glitches are rejected, a 4-cycle press counts.
        bus.ext_in[31:0] = 32'h0000_0002;
        bus.ext_btn[0] = 1'b1;
        step(2);
        bus.ext_btn[0] = 1'b0;
        step(6);
        bus.ext_in[31:0] = 32'h0000_0003;
        bus.ext_btn[0] = 1'b1;
        step(3);
        bus.ext_btn[0] = 1'b0;
        step(6);
        check("ch0_glitch_no_overrun", {127'd0, bus.overrun[0]}, 128'd0);
        bus.ext_in[31:0] = 32'h0000_0004;
        push_in(0, 32'h0000_0004);
        bus.ext_btn[0] = 1'b1;
        step(4);
        bus.ext_btn[0] = 1'b0;
        step(6);
        bus.enter_out[0] = 1'b1;
        step(4);
        bus.enter_out[0] = 1'b0;
        step(2);
        check("ch0_no_overrun", {127'd0, bus.overrun[0]}, 128'd0);

        // ch1: two presses before any request -> overrun, oldest (5) kept.
        bus.ext_in[63:32] = 32'd5;
        push_in(1, 32'd5);
        bus.ext_btn[1] = 1'b1;
        step(10);
        bus.ext_btn[1] = 1'b0;
        step(4);
        check("ch1_overrun_clear", {127'd0, bus.overrun[1]}, 128'd0);
        bus.ext_in[63:32] = 32'd9;
        bus.ext_btn[1] = 1'b1;
        step(10);
        bus.ext_btn[1] = 1'b0;
        step(4);
        check("ch1_overrun_set", {127'd0, bus.overrun[1]}, 128'd1);
        bus.enter_out[1] = 1'b1;
        step(1);
        check("ch1_data", {96'd0, bus.dev_in[63:32]}, 128'd5);
        step(3);
        bus.enter_out[1] = 1'b0;
        step(2);
        bus.enter_out[1] = 1'b1;
        step(4);
        bus.enter_out[1] = 1'b0;
        step(2);

        // ch0+ch1: press and request in the same cycle, both channels at once.
        bus.ext_in[31:0]  = 32'h0000_0077;
        bus.ext_in[63:32] = 32'h0000_0088;
        push_in(0, 32'h0000_0077);
        push_in(1, 32'h0000_0088);
        bus.ext_btn[1:0] = 2'b11;
        step(5);
        bus.enter_out[1:0] = 2'b11;
        step(1);
        check("same_cycle_captured", {124'd0, bus.enter_in}, 128'd0);
        step(1);
        check("same_cycle_delivered", {124'd0, bus.enter_in}, 128'h3);
        bus.ext_btn[1:0] = 2'b00;
        step(3);
        bus.enter_out[1:0] = 2'b00;
        step(3);

        // ch2: capture 0xCAFE, ack ACK_DELAY+1 cycles after capture.
        bus.dev_out[95:64] = 32'h0000_CAFE;
        push_out(2, 32'h0000_CAFE);
        bus.enter_out[2] = 1'b1;
        step(1);
        check("ch2_strobe", {127'd0, bus.ext_out_valid[2]}, 128'd1);
        check("ch2_ext_out", {96'd0, bus.ext_out[95:64]}, {96'd0, 32'h0000_CAFE});
        step(1);
        check("ch2_strobe_off", {127'd0, bus.ext_out_valid[2]}, 128'd0);
        step(2);
        check("ch2_done_early", {127'd0, bus.done_out[2]}, 128'd0);
        step(1);
        check("ch2_done_set", {127'd0, bus.done_out[2]}, 128'd1);
        step(3);
        check("ch2_done_hold", {127'd0, bus.done_out[2]}, 128'd1);
        bus.enter_out[2] = 1'b0;
        step(1);
        check("ch2_done_clear", {127'd0, bus.done_out[2]}, 128'd0);
        step(2);

        // ch2: request dropped and re-raised during BUSY -> re-rise ignored.
        bus.dev_out[95:64] = 32'h0000_1111;
        push_out(2, 32'h0000_1111);
        bus.enter_out[2] = 1'b1;
        step(1);
        bus.enter_out[2] = 1'b0;
        step(1);
        bus.dev_out[95:64] = 32'h0000_2222;
        bus.enter_out[2] = 1'b1;
        step(3);
        check("ch2_busy_ack", {127'd0, bus.done_out[2]}, 128'd1);
        check("ch2_busy_kept", {96'd0, bus.ext_out[95:64]}, {96'd0, 32'h0000_1111});
        bus.enter_out[2] = 1'b0;
        step(1);
        check("ch2_busy_clear", {127'd0, bus.done_out[2]}, 128'd0);
        step(2);

        // ch3: reset mid-transfer abandons it; a later request works normally.
        bus.dev_out[127:96] = 32'h0000_BEEF;
        push_out(3, 32'h0000_BEEF);
        bus.enter_out[3] = 1'b1;
        step(2);
        reset = 1'b1;
        bus.enter_out[3] = 1'b0;
        step(2);
        check("ch3_rst_done", {124'd0, bus.done_out}, 128'd0);
        check("ch3_rst_ext_out", bus.ext_out, 128'd0);
        reset = 1'b0;
        step(6);
        check("ch3_no_ack_after_rst", {124'd0, bus.done_out}, 128'd0);
        bus.dev_out[127:96] = 32'h0000_5A5A;
        push_out(3, 32'h0000_5A5A);
        bus.enter_out[3] = 1'b1;
        step(1);
        check("ch3_ext_out", {96'd0, bus.ext_out[127:96]}, {96'd0, 32'h0000_5A5A});
        step(4);
        check("ch3_done_set", {127'd0, bus.done_out[3]}, 128'd1);
        bus.enter_out[3] = 1'b0;
        step(1);
        check("ch3_done_clear", {127'd0, bus.done_out[3]}, 128'd0);
        check("in_ch_no_done", {126'd0, bus.done_out[1:0]}, 128'd0);
        check("out_ch_no_overrun", {126'd0, bus.overrun[3:2]}, 128'd0);
        step(3);

        check("in_q_drained", 128'(in_q.size()), 128'd0);
        check("out_q_drained", 128'(out_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
